// File: rtl/si5340_pkg.sv
// Shared types and constants for the Si5340 register-interface I2C responder.
// Latency: n/a (declarations only); backpressure: n/a.
package si5340_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_IGNORE,
      ST_DEV_ADDR,
      ST_DEV_ACK,
      ST_REG_ADDR,
      ST_REG_ACK,
      ST_WR_DATA,
      ST_WR_ACK,
      ST_RD_DATA,
      ST_RD_ACK
   } state_e;

   localparam logic [7:0] PAGE_REG_ADDR    = 8'h01;
   localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h74;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop SCL/SDA synchronizers with SCL edge and START/STOP strobes.
// Latency: strobes appear 2-3 clk_i after the pad edge; no backpressure.
module i2c_bus_sync (
   input  logic clk_i,
   input  logic arst_i,
   input  logic scl_i,
   input  logic sda_i,
   output logic sda_o,
   output logic scl_rise_o,
   output logic scl_fall_o,
   output logic start_o,
   output logic stop_o
);

   // [0],[1] form the synchronizer, [2] is the synchronized level one cycle earlier.
   logic [2:0] scl_q, scl_d;
   logic [2:0] sda_q, sda_d;

   assign scl_d = {scl_q[1:0], scl_i};
   assign sda_d = {sda_q[1:0], sda_i};

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= scl_d;
         sda_q <= sda_d;
      end
   end

   assign sda_o      = sda_q[1];
   assign scl_rise_o = scl_q[1] & ~scl_q[2];
   assign scl_fall_o = ~scl_q[1] & scl_q[2];
   assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
   assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

// File: rtl/si5340_i2c_responder.sv
// I2C target modelling the Si5340 paged register file; reports each accepted write byte.
// Latency: SDA changes 1 clk_i after a synchronized SCL fall, wr_valid_o 1 clk_i after the 8th data bit; no backpressure.
module si5340_i2c_responder
   import si5340_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR = DEFAULT_DEV_ADDR,
   parameter int unsigned PAGE_W   = 2
) (
   input  logic       clk_i,
   input  logic       arst_i,
   input  logic       scl_pad_i,
   input  logic       sda_pad_i,
   output logic       sda_pad_o,
   output logic       sda_padoen_o,
   output logic       wr_valid_o,
   output logic [7:0] wr_page_o,
   output logic [7:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       busy_o
);

   localparam int unsigned DEPTH = 2 ** (PAGE_W + 8);

   logic sda_s, scl_rise, scl_fall, start, stop;

   i2c_bus_sync u_sync (
      .clk_i      (clk_i),
      .arst_i     (arst_i),
      .scl_i      (scl_pad_i),
      .sda_i      (sda_pad_i),
      .sda_o      (sda_s),
      .scl_rise_o (scl_rise),
      .scl_fall_o (scl_fall),
      .start_o    (start),
      .stop_o     (stop)
   );

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [7:0]        shift_q, shift_d;
   logic [7:0]        tx_q, tx_d;
   logic [7:0]        ptr_q, ptr_d;
   logic [7:0]        page_q, page_d;
   logic              rw_q, rw_d;
   logic              drive_q, drive_d;
   logic              busy_q, busy_d;
   logic              wr_valid_q, wr_valid_d;
   logic [7:0]        wr_page_q, wr_page_d;
   logic [7:0]        wr_addr_q, wr_addr_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic              mem_we;
   logic [7:0]        mem_rd_q;
   logic [7:0]        mem_q [DEPTH];
   logic [PAGE_W+7:0] mem_addr;
   logic [7:0]        byte_in;
   logic [7:0]        rd_byte;

   assign mem_addr = {page_q[PAGE_W-1:0], ptr_q};
   assign byte_in  = {shift_q[6:0], sda_s};
   assign rd_byte  = (ptr_q == PAGE_REG_ADDR) ? page_q : mem_q_rd_sel();

   function automatic logic [7:0] mem_q_rd_sel();
      return mem_rd_q;
   endfunction

   // Register file holds no reset; it reads the current pointer every cycle.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[mem_addr] <= byte_in;
      mem_rd_q <= mem_q[mem_addr];
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      tx_d       = tx_q;
      ptr_d      = ptr_q;
      page_d     = page_q;
      rw_d       = rw_q;
      drive_d    = drive_q;
      busy_d     = busy_q;
      wr_valid_d = 1'b0;
      wr_page_d  = wr_page_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      mem_we     = 1'b0;
      if (start) begin
         state_d = ST_DEV_ADDR;
         cnt_d   = '0;
         drive_d = 1'b0;
         busy_d  = 1'b1;
      end else if (stop) begin
         state_d = ST_IDLE;
         drive_d = 1'b0;
         busy_d  = 1'b0;
      end else begin
         case (state_q)
            ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d = byte_in;
                  cnt_d   = cnt_q + 4'd1;
                  if (cnt_q == 4'd7) begin
                     cnt_d = '0;
                     if (state_q == ST_DEV_ADDR) begin
                        rw_d    = byte_in[0];
                        state_d = (byte_in[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_IGNORE;
                     end else if (state_q == ST_REG_ADDR) begin
                        ptr_d   = byte_in;
                        state_d = ST_REG_ACK;
                     end else begin
                        mem_we     = 1'b1;
                        wr_valid_d = 1'b1;
                        wr_page_d  = page_q;
                        wr_addr_d  = ptr_q;
                        wr_data_d  = byte_in;
                        ptr_d      = ptr_q + 8'd1;
                        if (ptr_q == PAGE_REG_ADDR) page_d = byte_in;
                        state_d    = ST_WR_ACK;
                     end
                  end
               end
            end
            // First fall after the 8th bit pulls SDA low, the next one releases it.
            ST_DEV_ACK, ST_REG_ACK, ST_WR_ACK: begin
               if (scl_fall) begin
                  if (!drive_q) begin
                     drive_d = 1'b1;
                  end else begin
                     drive_d = 1'b0;
                     cnt_d   = '0;
                     if (state_q == ST_DEV_ACK && rw_q) begin
                        state_d = ST_RD_DATA;
                        drive_d = ~rd_byte[7];
                        tx_d    = {rd_byte[6:0], 1'b0};
                     end else if (state_q == ST_DEV_ACK) begin
                        state_d = ST_REG_ADDR;
                     end else begin
                        state_d = ST_WR_DATA;
                     end
                  end
               end
            end
            ST_RD_DATA: begin
               if (scl_rise) begin
                  cnt_d = cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (cnt_q == 4'd8) begin
                     drive_d = 1'b0;
                     cnt_d   = '0;
                     state_d = ST_RD_ACK;
                  end else begin
                     drive_d = ~tx_q[7];
                     tx_d    = {tx_q[6:0], 1'b0};
                  end
               end
            end
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_s) state_d = ST_IGNORE;
                  else       ptr_d   = ptr_q + 8'd1;
               end else if (scl_fall) begin
                  state_d = ST_RD_DATA;
                  cnt_d   = '0;
                  drive_d = ~rd_byte[7];
                  tx_d    = {rd_byte[6:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         shift_q    <= '0;
         tx_q       <= '0;
         ptr_q      <= '0;
         page_q     <= '0;
         rw_q       <= 1'b0;
         drive_q    <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_page_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         tx_q       <= tx_d;
         ptr_q      <= ptr_d;
         page_q     <= page_d;
         rw_q       <= rw_d;
         drive_q    <= drive_d;
         busy_q     <= busy_d;
         wr_valid_q <= wr_valid_d;
         wr_page_q  <= wr_page_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign sda_pad_o    = 1'b0;
   assign sda_padoen_o = ~drive_q;
   assign wr_valid_o   = wr_valid_q;
   assign wr_page_o    = wr_page_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign busy_o       = busy_q;

endmodule
